quiz_arbiter: RTL and testbench
===============================

# quiz_arbiter

Parametrised quiz-buzzer core for the answer-competition game: arbitrates first-press among up to N_PLAYERS contestants during a selectable per-round countdown. It flags false starts, keeps saturating per-player scores, and drives a beeper pulse. It sits between the debounced switch/button inputs and the 7-segment/LED display logic. It replaces the fixed two/four-player countdown-plus-answer pairing with one synchronous engine.

## Interface
- N_PLAYERS, 4, number of contestant channels (2..8)
- TICK_DIV, 100000000, clk cycles per countdown second (>=2)
- LONG_SEC, 30, round length when time_select=1 (1..99)
- SHORT_SEC, 20, round length when time_select=0 (1..99)
- SCORE_W, 4, bits per player score
- ALARM_CYC, 50000000, alarm pulse length in clk cycles (>=1)
- PENALTY, 0, 1 = judge_no decrements winner score (saturating at 0); 0 = no change

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  round-enable level switch (count_down)
- time_select  in  1  1 = LONG_SEC, 0 = SHORT_SEC; sampled only on round start
- num_players  in  3  active players; 0 or >N_PLAYERS treated as N_PLAYERS
- buzz  in  N_PLAYERS  player buttons, level, pre-debounced
- judge_yes, judge_no  in  1  host verdict, level
- state  out  3  0 IDLE, 1 ARMED, 2 LOCKED, 3 DONE, 4 TIMEOUT
- winner_led  out  N_PLAYERS  one-hot answering player
- winner_idx  out  3  binary index of winner
- sec_tens, sec_ones  out  4 each  remaining seconds, BCD
- foul  out  N_PLAYERS  false-start flags
- scores  out  N_PLAYERS*SCORE_W  player i at bits [i*SCORE_W +: SCORE_W]
- alarm  out  1  beeper drive

## Operation
- Enabled mask: bit i = 1 iff i < effective num_players. Disabled players are ignored everywhere.
- IDLE:
  - buzz[i] high on an enabled player sets foul[i].
  - On a rising edge of start (registered start_d=0, start=1), go to ARMED. Load the seconds counter from time_select, clear the tick counter, clear winner_led.
- ARMED:
  - Tick counter counts 0..TICK_DIV-1. On wrap, seconds decrement.
  - Valid presses are buzz & enabled & ~foul. If any are valid, the winner is the lowest index among them. Go to LOCKED, set winner_led/winner_idx, freeze the seconds, fire alarm.
  - If the seconds reach 0 with no valid press, go to TIMEOUT and fire alarm.
  - A press takes priority over the second reaching 0 in the same cycle.
- LOCKED: wait for the verdict.
  - judge_yes: winner score +1, saturating at 2^SCORE_W-1.
  - judge_no: score -1 saturating at 0 if PENALTY=1, else unchanged.
  - Either verdict goes to DONE. judge_yes wins if both are high.
- DONE / TIMEOUT: outputs hold. start low returns to IDLE and clears foul on that transition.
- start low in ARMED or LOCKED: abort to IDLE. No score change; foul is cleared.
- Alarm: high for ALARM_CYC cycles from the firing cycle. Re-firing restarts the count.
- BCD: seconds are kept as a binary counter and converted to tens/ones combinationally from registered state. Alternatively they are kept as a direct BCD down-counter. Either way the output matches the binary value.

## Timing
- Reset values: state IDLE, winner_led 0, winner_idx 0, sec 00, foul 0, scores all 0, alarm 0, internal start_d 0, tick 0.
- ARMED entry: one cycle after the start rising edge is sampled. sec shows the loaded value that cycle.
- First decrement: TICK_DIV cycles after ARMED entry. Then every TICK_DIV cycles.
- Winner latency: valid buzz sampled at edge k gives state=LOCKED, winner_led, and alarm=1 after edge k.
- Score update is visible the same edge that state becomes DONE.
- rst overrides everything, including mid-round and mid-alarm.
- time_select and num_players changes during a round are ignored for that round.

## Test plan
- Reset, N_PLAYERS=4, TICK_DIV=4: all outputs at their reset values; start rising -> state=1, sec=30 (time_select=1), sec=29 after 4 cycles.
- Simultaneous buzz=4'b0110 in ARMED -> winner_idx=1, winner_led=0010, alarm high exactly ALARM_CYC cycles, sec frozen.
- buzz[0] held in IDLE, then start -> foul=0001. buzz=0001 in ARMED is ignored. buzz=1000 afterwards wins idx 3.
- num_players=2, buzz=1100 only -> no winner. SHORT_SEC=20 at TICK_DIV=4 reaches 0 after 80 cycles -> state=4, alarm fires.
- SCORE_W=2: four judge_yes rounds for player 2 -> score 3 (saturates). PENALTY=1 judge_no at 0 -> stays 0. yes+no together -> +1.
- start dropped in LOCKED -> state=0 next cycle, scores unchanged, foul cleared. rst asserted mid-ARMED -> all reset values next cycle.

Source files
------------

// File: rtl/quiz_arbiter.sv
// quiz_arbiter: first-press buzzer arbitration with a per-round countdown,
// false-start detection, saturating per-player scores and a beeper pulse.
module quiz_arbiter #(
  parameter int N_PLAYERS = 4,
  parameter int TICK_DIV  = 100000000,
  parameter int LONG_SEC  = 30,
  parameter int SHORT_SEC = 20,
  parameter int SCORE_W   = 4,
  parameter int ALARM_CYC = 50000000,
  parameter int PENALTY   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           time_select,
  input  logic [2:0]                     num_players,
  input  logic [N_PLAYERS-1:0]           buzz,
  input  logic                           judge_yes,
  input  logic                           judge_no,
  output logic [2:0]                     state,
  output logic [N_PLAYERS-1:0]           winner_led,
  output logic [2:0]                     winner_idx,
  output logic [3:0]                     sec_tens,
  output logic [3:0]                     sec_ones,
  output logic [N_PLAYERS-1:0]           foul,
  output logic [N_PLAYERS*SCORE_W-1:0]   scores,
  output logic                           alarm
);

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int ALM_W  = (ALARM_CYC > 1) ? $clog2(ALARM_CYC + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t                         state_r, state_n;
  logic                           start_d_r;
  logic [TICK_W-1:0]              tick_r, tick_n;
  logic [6:0]                     sec_r, sec_n;
  logic [N_PLAYERS-1:0]           led_r, led_n;
  logic [2:0]                     idx_r, idx_n;
  logic [N_PLAYERS-1:0]           foul_r, foul_n;
  logic [N_PLAYERS-1:0]           mask_r, mask_n;
  logic [N_PLAYERS*SCORE_W-1:0]   scores_r, scores_n;
  logic                           alarm_r;
  logic [ALM_W-1:0]               alarm_cnt_r;
  logic                           fire_s;
  logic                           start_rise_s;
  logic [N_PLAYERS-1:0]           en_live_s;
  logic [N_PLAYERS-1:0]           valid_s;
  logic [2:0]                     win_idx_s;

  // Saturating increment of one score field.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v == {SCORE_W{1'b1}}) return v;
    else return v + SCORE_W'(1);
  endfunction

  // Saturating decrement of one score field.
  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
    if (v == {SCORE_W{1'b0}}) return v;
    else return v - SCORE_W'(1);
  endfunction

  // Lowest set bit index; lower-numbered players win simultaneous presses.
  function automatic logic [2:0] lowest_idx(input logic [N_PLAYERS-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
      else r = r;
    end
    return r;
  endfunction

  // Enabled-player mask; out-of-range player counts mean "everyone".
  function automatic logic [N_PLAYERS-1:0] player_mask(input logic [2:0] n);
    logic [3:0]           eff;
    logic [N_PLAYERS-1:0] m;
    if (n == 3'd0 || {1'b0, n} > 4'(N_PLAYERS)) eff = 4'(N_PLAYERS);
    else eff = {1'b0, n};
    for (int i = 0; i < N_PLAYERS; i++) m[i] = (4'(i) < eff);
    return m;
  endfunction

  assign start_rise_s = start & ~start_d_r;
  assign en_live_s    = player_mask(num_players);
  // The mask latched at round start keeps mid-round num_players changes out.
  assign valid_s      = buzz & mask_r & ~foul_r;
  assign win_idx_s    = lowest_idx(valid_s);

  // Next-state and datapath updates for the round FSM.
  always_comb begin
    state_n  = state_r;
    tick_n   = tick_r;
    sec_n    = sec_r;
    led_n    = led_r;
    idx_n    = idx_r;
    foul_n   = foul_r;
    mask_n   = mask_r;
    scores_n = scores_r;
    fire_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        foul_n = foul_r | (buzz & en_live_s);
        if (start_rise_s) begin
          state_n = ST_ARMED;
          sec_n   = time_select ? 7'(LONG_SEC) : 7'(SHORT_SEC);
          tick_n  = '0;
          led_n   = '0;
          idx_n   = 3'd0;
          mask_n  = en_live_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!start) begin
          state_n = ST_IDLE;
          foul_n  = '0;
        end else if (|valid_s) begin
          // A press beats an expiring second in the same cycle.
          state_n = ST_LOCKED;
          idx_n   = win_idx_s;
          led_n   = N_PLAYERS'(1) << win_idx_s;
          fire_s  = 1'b1;
        end else if (tick_r == TICK_W'(TICK_DIV - 1)) begin
          tick_n = '0;
          if (sec_r <= 7'd1) begin
            sec_n   = 7'd0;
            state_n = ST_TIMEOUT;
            fire_s  = 1'b1;
          end else begin
            sec_n = sec_r - 7'd1;
          end
        end else begin
          tick_n = tick_r + TICK_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!start) begin
          state_n = ST_IDLE;
          foul_n  = '0;
        end else if (judge_yes || judge_no) begin
          state_n = ST_DONE;
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (led_r[i] && judge_yes) begin
              scores_n[i*SCORE_W +: SCORE_W] = sat_inc(scores_r[i*SCORE_W +: SCORE_W]);
            end else if (led_r[i] && (PENALTY != 0)) begin
              scores_n[i*SCORE_W +: SCORE_W] = sat_dec(scores_r[i*SCORE_W +: SCORE_W]);
            end else begin
              scores_n[i*SCORE_W +: SCORE_W] = scores_r[i*SCORE_W +: SCORE_W];
            end
          end
        end else begin
          state_n = ST_LOCKED;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (!start) begin
          state_n = ST_IDLE;
          foul_n  = '0;
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Round state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      start_d_r <= 1'b0;
      tick_r    <= '0;
      sec_r     <= 7'd0;
      led_r     <= '0;
      idx_r     <= 3'd0;
      foul_r    <= '0;
      mask_r    <= '0;
      scores_r  <= '0;
    end else begin
      state_r   <= state_n;
      start_d_r <= start;
      tick_r    <= tick_n;
      sec_r     <= sec_n;
      led_r     <= led_n;
      idx_r     <= idx_n;
      foul_r    <= foul_n;
      mask_r    <= mask_n;
      scores_r  <= scores_n;
    end
  end

  // Beeper pulse: ALARM_CYC cycles from the firing edge, refire restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_r     <= 1'b0;
      alarm_cnt_r <= '0;
    end else if (fire_s) begin
      alarm_r     <= 1'b1;
      alarm_cnt_r <= ALM_W'(ALARM_CYC - 1);
    end else if (alarm_cnt_r != '0) begin
      alarm_r     <= 1'b1;
      alarm_cnt_r <= alarm_cnt_r - ALM_W'(1);
    end else begin
      alarm_r     <= 1'b0;
      alarm_cnt_r <= '0;
    end
  end

  assign state      = state_r;
  assign winner_led = led_r;
  assign winner_idx = idx_r;
  assign sec_tens   = 4'(sec_r / 7'd10);
  assign sec_ones   = 4'(sec_r % 7'd10);
  assign foul       = foul_r;
  assign scores     = scores_r;
  assign alarm      = alarm_r;

endmodule

// File: tb/tb_quiz_arbiter.sv
// Scoreboard bench for quiz_arbiter: stimulus queues time-stamped
// expectations, a negedge monitor pops and compares them.
module tb_quiz_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst, start, time_select, judge_yes, judge_no;
  logic [2:0]       num_players;
  logic [N-1:0]     buzz;
  logic [2:0]       state, winner_idx;
  logic [N-1:0]     winner_led, foul;
  logic [3:0]       sec_tens, sec_ones;
  logic [N*SW-1:0]  scores;
  logic             alarm;

  quiz_arbiter #(
    .N_PLAYERS(N), .TICK_DIV(4), .LONG_SEC(30), .SHORT_SEC(20),
    .SCORE_W(SW), .ALARM_CYC(6), .PENALTY(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .time_select(time_select),
    .num_players(num_players), .buzz(buzz), .judge_yes(judge_yes),
    .judge_no(judge_no), .state(state), .winner_led(winner_led),
    .winner_idx(winner_idx), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .foul(foul), .scores(scores), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sc[N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'(state);
      1: return 32'(winner_led);
      2: return 32'(winner_idx);
      3: return 32'({sec_tens, sec_ones});
      4: return 32'(foul);
      5: return 32'(scores);
      6: return 32'(alarm);
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every expectation whose cycle stamp has come due.
  always @(negedge clk) begin
    logic [31:0] got;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].stamp <= cyc) begin
        got = pick(q[i].sel);
        n_checks++;
        if (q[i].stamp < cyc || got !== q[i].exp) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got %0h expected %0h", q[i].name, cyc, got, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.stamp = cyc + dly;
    c.name  = nm;
    c.sel   = sel;
    c.exp   = v;
    q.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_scores();
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < N; i++) r = r | (32'(sc[i]) << (SW * i));
    return r;
  endfunction

  task automatic expect_reset(input int dly, input string tag);
    expect_at(dly, {tag, "_state"},  0, 32'd0);
    expect_at(dly, {tag, "_led"},    1, 32'd0);
    expect_at(dly, {tag, "_idx"},    2, 32'd0);
    expect_at(dly, {tag, "_sec"},    3, 32'h00);
    expect_at(dly, {tag, "_foul"},   4, 32'd0);
    expect_at(dly, {tag, "_scores"}, 5, 32'd0);
    expect_at(dly, {tag, "_alarm"},  6, 32'd0);
  endtask

  // One judged round: player p presses, host gives yes/no.
  task automatic judged_round(input int p, input logic y, input logic n);
    start = 1'b1;
    step(1);
    buzz = 4'(1 << p);
    expect_at(1, "rnd_state_locked", 0, 32'd2);
    expect_at(1, "rnd_idx", 2, 32'(p));
    step(1);
    buzz = 4'b0000;
    judge_yes = y;
    judge_no  = n;
    if (y) sc[p] = (sc[p] < 3) ? sc[p] + 1 : 3;
    else if (n) sc[p] = (sc[p] > 0) ? sc[p] - 1 : 0;
    else sc[p] = sc[p];
    expect_at(1, "rnd_state_done", 0, 32'd3);
    expect_at(1, "rnd_scores", 5, model_scores());
    step(1);
    judge_yes = 1'b0;
    judge_no  = 1'b0;
    start = 1'b0;
    expect_at(1, "rnd_state_idle", 0, 32'd0);
    step(1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) sc[i] = 0;
    rst = 1'b1; start = 1'b0; time_select = 1'b1; num_players = 3'd4;
    buzz = 4'b0000; judge_yes = 1'b0; judge_no = 1'b0;
    step(2);
    rst = 1'b0;
    expect_reset(0, "rst");

    // Round start with long countdown, then first decrement.
    start = 1'b1;
    expect_at(1, "arm_state", 0, 32'd1);
    expect_at(1, "arm_sec30", 3, 32'h30);
    step(1);
    expect_at(3, "sec_still30", 3, 32'h30);
    expect_at(4, "sec29", 3, 32'h29);
    step(4);

    // Simultaneous press: lowest index wins, seconds freeze, alarm pulse.
    buzz = 4'b0110;
    expect_at(1, "win_state", 0, 32'd2);
    expect_at(1, "win_idx1", 2, 32'd1);
    expect_at(1, "win_led", 1, 32'b0010);
    expect_at(1, "alarm_on", 6, 32'd1);
    expect_at(6, "alarm_last", 6, 32'd1);
    expect_at(7, "alarm_off", 6, 32'd0);
    expect_at(9, "sec_frozen", 3, 32'h29);
    step(1);
    buzz = 4'b0000;
    step(9);
    judge_yes = 1'b1;
    sc[1] = 1;
    expect_at(1, "yes_done", 0, 32'd3);
    expect_at(1, "yes_score", 5, model_scores());
    step(1);
    judge_yes = 1'b0;
    start = 1'b0;
    expect_at(1, "back_idle", 0, 32'd0);
    step(1);

    // False start by player 0, ignored in ARMED, player 3 then wins.
    buzz = 4'b0001;
    expect_at(1, "foul_set", 4, 32'b0001);
    step(1);
    start = 1'b1;
    expect_at(1, "foul_arm", 0, 32'd1);
    expect_at(1, "foul_kept", 4, 32'b0001);
    step(3);
    expect_at(0, "foul_ignored", 0, 32'd1);
    buzz = 4'b1001;
    expect_at(1, "win3_state", 0, 32'd2);
    expect_at(1, "win3_idx", 2, 32'd3);
    expect_at(1, "win3_led", 1, 32'b1000);
    step(1);
    buzz = 4'b0000;
    // Abort from LOCKED.
    start = 1'b0;
    expect_at(1, "abort_idle", 0, 32'd0);
    expect_at(1, "abort_foul", 4, 32'd0);
    expect_at(1, "abort_scores", 5, model_scores());
    step(1);

    // Two players, disabled buttons held, short countdown runs out.
    num_players = 3'd2; time_select = 1'b0; buzz = 4'b1100; start = 1'b1;
    expect_at(1, "to_arm", 0, 32'd1);
    expect_at(1, "to_sec20", 3, 32'h20);
    expect_at(1, "to_nofoul", 4, 32'd0);
    step(1);
    num_players = 3'd4; time_select = 1'b1;
    expect_at(79, "to_sec01", 3, 32'h01);
    expect_at(79, "to_still_armed", 0, 32'd1);
    expect_at(80, "to_state", 0, 32'd4);
    expect_at(80, "to_sec00", 3, 32'h00);
    expect_at(80, "to_alarm", 6, 32'd1);
    expect_at(86, "to_alarm_off", 6, 32'd0);
    step(87);
    buzz = 4'b0000; start = 1'b0;
    expect_at(1, "to_idle", 0, 32'd0);
    step(1);

    // Score saturation, penalty floor, yes-over-no, penalty decrement.
    for (int r = 0; r < 4; r++) judged_round(2, 1'b1, 1'b0);
    judged_round(0, 1'b0, 1'b1);
    judged_round(3, 1'b1, 1'b1);
    judged_round(1, 1'b0, 1'b1);

    // Reset in the middle of an armed round.
    start = 1'b1;
    step(3);
    rst = 1'b1;
    expect_reset(1, "mid_rst");
    step(1);
    rst = 1'b0; start = 1'b0;
    step(1);

    for (int k = 0; k < 200 && q.size() > 0; k++) step(1);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
      n_checks += q.size();
      n_fail   += q.size();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
